// File: rtl/mipi_dphy_hs_seq.sv
// MIPI D-PHY data-lane sequencer: walks one lane LP-11 -> SoT -> payload -> EoT -> LP-11.
// All outputs are registered and decoded from the next state.
module mipi_dphy_hs_seq #(
    parameter int unsigned T_LPX        = 3,
    parameter int unsigned T_HS_PREPARE = 3,
    parameter int unsigned T_HS_ZERO    = 8,
    parameter int unsigned T_HS_TRAIL   = 4,
    parameter int unsigned T_HS_EXIT    = 6,
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       tx_req,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       lp_p,
    output logic       lp_n,
    output logic       hs_en,
    output logic [7:0] hs_data,
    output logic       busy,
    output logic       underrun
);

    // state | meaning
    // IDLE  | LP-11, waiting for tx_req
    // LPX   | LP-01 for T_LPX cycles
    // PREP  | LP-00, HS driver off, T_HS_PREPARE cycles
    // ZERO  | HS-0 (0x00) for T_HS_ZERO cycles
    // SYNC  | leader byte for one cycle, first byte may be accepted
    // DATA  | payload bytes, one cycle behind acceptance
    // TRAIL | inverted bit7 of last byte, T_HS_TRAIL cycles
    // EXIT  | LP-11 for T_HS_EXIT cycles, tx_req ignored
    typedef enum logic [2:0] {
        S_IDLE, S_LPX, S_PREP, S_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT
    } state_t;

    localparam int unsigned M_A   = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
    localparam int unsigned M_B   = (T_HS_ZERO > T_HS_TRAIL) ? T_HS_ZERO : T_HS_TRAIL;
    localparam int unsigned M_C   = (M_A > M_B) ? M_A : M_B;
    localparam int unsigned T_MAX = (M_C > T_HS_EXIT) ? M_C : T_HS_EXIT;
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] LD_LPX   = CNT_W'(T_LPX - 1);
    localparam logic [CNT_W-1:0] LD_PREP  = CNT_W'(T_HS_PREPARE - 1);
    localparam logic [CNT_W-1:0] LD_ZERO  = CNT_W'(T_HS_ZERO - 1);
    localparam logic [CNT_W-1:0] LD_TRAIL = CNT_W'(T_HS_TRAIL - 1);
    localparam logic [CNT_W-1:0] LD_EXIT  = CNT_W'(T_HS_EXIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hs_data_q, hs_data_d;
    logic             tx_ready_q, tx_ready_d;
    logic             underrun_q, underrun_d;
    logic             lp_p_q, lp_p_d;
    logic             lp_n_q, lp_n_d;
    logic             hs_en_q, hs_en_d;
    logic             busy_q, busy_d;
    logic             cnt_done;

    assign cnt_done = (cnt_q == '0);

    // Trail holds the opposite level of the final transmitted bit.
    function automatic logic [7:0] trail_of(input logic [7:0] b);
        return b[7] ? 8'h00 : 8'hFF;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hs_data_d  = hs_data_q;
        tx_ready_d = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_req) begin
                    state_d = S_LPX;
                    cnt_d   = LD_LPX;
                end
            end
            S_LPX: begin
                if (cnt_done) begin
                    state_d = S_PREP;
                    cnt_d   = LD_PREP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PREP: begin
                if (cnt_done) begin
                    state_d   = S_ZERO;
                    cnt_d     = LD_ZERO;
                    hs_data_d = 8'h00;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ZERO: begin
                if (cnt_done) begin
                    state_d    = S_SYNC;
                    cnt_d      = '0;
                    hs_data_d  = SYNC_BYTE;
                    tx_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SYNC, S_DATA: begin
                // A ready cycle without valid ends the burst; the byte on the wire is the last one.
                if (tx_ready_q && tx_valid) begin
                    state_d    = S_DATA;
                    hs_data_d  = tx_data;
                    tx_ready_d = !tx_last;
                end else begin
                    state_d    = S_TRAIL;
                    cnt_d      = LD_TRAIL;
                    hs_data_d  = trail_of(hs_data_q);
                    underrun_d = tx_ready_q;
                end
            end
            S_TRAIL: begin
                if (cnt_done) begin
                    state_d   = S_EXIT;
                    cnt_d     = LD_EXIT;
                    hs_data_d = 8'h00;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EXIT: begin
                if (cnt_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                hs_data_d = 8'h00;
            end
        endcase

        lp_p_d  = 1'b1;
        lp_n_d  = 1'b1;
        hs_en_d = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_LPX: lp_p_d = 1'b0;
            S_PREP: begin
                lp_p_d = 1'b0;
                lp_n_d = 1'b0;
            end
            S_ZERO, S_SYNC, S_DATA, S_TRAIL: begin
                lp_p_d  = 1'b0;
                lp_n_d  = 1'b0;
                hs_en_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hs_data_q  <= 8'h00;
            tx_ready_q <= 1'b0;
            underrun_q <= 1'b0;
            lp_p_q     <= 1'b1;
            lp_n_q     <= 1'b1;
            hs_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hs_data_q  <= hs_data_d;
            tx_ready_q <= tx_ready_d;
            underrun_q <= underrun_d;
            lp_p_q     <= lp_p_d;
            lp_n_q     <= lp_n_d;
            hs_en_q    <= hs_en_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign lp_p     = lp_p_q;
    assign lp_n     = lp_n_q;
    assign hs_en    = hs_en_q;
    assign hs_data  = hs_data_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_mipi_dphy_hs_seq.sv
// Bench for mipi_dphy_hs_seq: a per-cycle expected lane trace is queued per burst and
// popped by an independent monitor; a second instance runs with all timings at 1.
module tb_mipi_dphy_hs_seq;

    localparam int T_LPX   = 3;
    localparam int T_PREP  = 3;
    localparam int T_ZERO  = 8;
    localparam int T_TRAIL = 4;
    localparam int T_EXIT  = 6;
    localparam logic [7:0] SYNC = 8'hB8;

    typedef struct packed {
        logic [1:0] lp;
        logic       hs_en;
        logic [7:0] data;
        logic       ready;
        logic       und;
    } exp_t;

    logic       clk_50m;
    logic       rst_n;
    logic       tx_req;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;

    logic       rdy0, lpp0, lpn0, hse0, busy0, und0;
    logic [7:0] hsd0;
    logic       rdy1, lpp1, lpn1, hse1, busy1, und1;
    logic [7:0] hsd1;

    logic       tx_ready_s, lp_p_s, lp_n_s, hs_en_s, busy_s, underrun_s;
    logic [7:0] hs_data_s;

    exp_t       sb[$];
    logic [7:0] bq[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    bit         sel      = 1'b0;
    int         c;

    mipi_dphy_hs_seq u_dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .tx_req(tx_req), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_last(tx_last), .tx_ready(rdy0), .lp_p(lpp0), .lp_n(lpn0),
        .hs_en(hse0), .hs_data(hsd0), .busy(busy0), .underrun(und0)
    );

    mipi_dphy_hs_seq #(
        .T_LPX(1), .T_HS_PREPARE(1), .T_HS_ZERO(1), .T_HS_TRAIL(1), .T_HS_EXIT(1)
    ) u_dut_min (
        .clk_50m(clk_50m), .rst_n(rst_n), .tx_req(tx_req), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_last(tx_last), .tx_ready(rdy1), .lp_p(lpp1), .lp_n(lpn1),
        .hs_en(hse1), .hs_data(hsd1), .busy(busy1), .underrun(und1)
    );

    always_comb begin
        tx_ready_s = sel ? rdy1  : rdy0;
        lp_p_s     = sel ? lpp1  : lpp0;
        lp_n_s     = sel ? lpn1  : lpn0;
        hs_en_s    = sel ? hse1  : hse0;
        hs_data_s  = sel ? hsd1  : hsd0;
        busy_s     = sel ? busy1 : busy0;
        underrun_s = sel ? und1  : und0;
    end

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t sel=%0d)", nm, act, exp_v, $time, sel);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] lp, input logic hs, input logic [7:0] d,
                                input logic r, input logic u);
        exp_t e;
        e.lp = lp; e.hs_en = hs; e.data = d; e.ready = r; e.und = u;
        return e;
    endfunction

    // Reference lane trace for one burst of the bytes in bq, from the first LPX cycle to the last EXIT cycle.
    task automatic push_trace(input bit und);
        int tl, tp, tz, tt, te, n;
        logic [7:0] last_b, trail_b;
        if (sel) begin
            tl = 1; tp = 1; tz = 1; tt = 1; te = 1;
        end else begin
            tl = T_LPX; tp = T_PREP; tz = T_ZERO; tt = T_TRAIL; te = T_EXIT;
        end
        n = bq.size();
        repeat (tl) sb.push_back(mk(2'b01, 1'b0, 8'h00, 1'b0, 1'b0));
        repeat (tp) sb.push_back(mk(2'b00, 1'b0, 8'h00, 1'b0, 1'b0));
        repeat (tz) sb.push_back(mk(2'b00, 1'b1, 8'h00, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b1, SYNC, 1'b1, 1'b0));
        for (int i = 0; i < n; i++)
            sb.push_back(mk(2'b00, 1'b1, bq[i], und ? 1'b1 : (i < n - 1), 1'b0));
        last_b  = bq[n-1];
        trail_b = last_b[7] ? 8'h00 : 8'hFF;
        for (int i = 0; i < tt; i++)
            sb.push_back(mk(2'b00, 1'b1, trail_b, 1'b0, und && (i == 0)));
        repeat (te) sb.push_back(mk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0));
    endtask

    // Issue one burst of bq; und=1 withholds valid after the last byte instead of flagging tx_last.
    task automatic run_burst(input bit und, input bit hold);
        int cnt, idx, guard, n;
        n = bq.size();
        push_trace(und);
        tx_req = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk_50m);
            cnt++;
        end while (!busy_s && cnt < 10);
        chk("req_to_lpx_cycles", cnt, 1);
        idx = 0;
        guard = 0;
        while (busy_s && guard < 400) begin
            if (tx_ready_s) begin
                if (idx < n) begin
                    tx_valid = 1'b1;
                    tx_data  = bq[idx];
                    tx_last  = !und && (idx == n - 1);
                    idx++;
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                    tx_last  = 1'($urandom);
                end
            end else begin
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom);
            end
            if (!hold && guard == 5) tx_req = 1'b0;
            @(negedge clk_50m);
            guard++;
        end
        if (guard >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL burst_timeout: actual=busy after %0d cycles required=idle", guard);
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        if (!hold) tx_req = 1'b0;
    endtask

    task automatic random_bursts(input int count);
        bit und, hold;
        int n;
        for (int k = 0; k < count; k++) begin
            n = $urandom_range(1, 8);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            und  = 1'($urandom);
            hold = (k < count - 1) ? 1'($urandom) : 1'b0;
            run_burst(und, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk_50m);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk_50m);
            if (mon_en) begin
                chk("lp_never_10", int'({lp_p_s, lp_n_s} != 2'b10), 1);
                chk("hs_en_implies_lp00", int'(!hs_en_s || ({lp_p_s, lp_n_s} == 2'b00)), 1);
                if (busy_s) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_underflow: actual=busy required=no burst expected (t=%0t)", $time);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("lp_level", int'({lp_p_s, lp_n_s}), int'(mon_e.lp));
                        chk("hs_en", int'(hs_en_s), int'(mon_e.hs_en));
                        chk("tx_ready", int'(tx_ready_s), int'(mon_e.ready));
                        chk("underrun", int'(underrun_s), int'(mon_e.und));
                        if (mon_e.hs_en) chk("hs_data", int'(hs_data_s), int'(mon_e.data));
                    end
                end else begin
                    chk("idle_lp11", int'({lp_p_s, lp_n_s}), 3);
                    chk("idle_hs_en", int'(hs_en_s), 0);
                    chk("idle_tx_ready", int'(tx_ready_s), 0);
                    chk("idle_underrun", int'(underrun_s), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: actual=still running required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n    = 1'b0;
        tx_req   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk_50m);
        chk("rst_lp_p", int'(lp_p_s), 1);
        chk("rst_lp_n", int'(lp_n_s), 1);
        chk("rst_hs_en", int'(hs_en_s), 0);
        chk("rst_hs_data", int'(hs_data_s), 0);
        chk("rst_tx_ready", int'(tx_ready_s), 0);
        chk("rst_busy", int'(busy_s), 0);
        chk("rst_underrun", int'(underrun_s), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_50m);

        bq = '{8'h11, 8'h22, 8'h33};
        run_burst(1'b0, 1'b0);
        bq = '{8'h7F, 8'h80};
        run_burst(1'b0, 1'b0);
        bq = '{8'hC3, 8'h3C};
        run_burst(1'b1, 1'b0);
        repeat (2) @(negedge clk_50m);
        bq = '{8'hA1, 8'h02};
        run_burst(1'b0, 1'b1);
        bq = '{8'h55};
        run_burst(1'b0, 1'b1);
        bq = '{8'hFF, 8'h00, 8'h81};
        run_burst(1'b0, 1'b0);
        random_bursts(12);

        mon_en = 1'b0;
        tx_req = 1'b1;
        c = 0;
        do begin
            @(negedge clk_50m);
            c++;
        end while (!tx_ready_s && c < 40);
        chk("rst_test_reach_sync", int'(tx_ready_s), 1);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        tx_last  = 1'b0;
        @(negedge clk_50m);
        chk("pre_rst_data", int'(hs_data_s), 8'h5A);
        tx_data = 8'hA5;
        #2 rst_n = 1'b0;
        #1;
        chk("midburst_rst_lp", int'({lp_p_s, lp_n_s}), 3);
        chk("midburst_rst_hs_en", int'(hs_en_s), 0);
        chk("midburst_rst_tx_ready", int'(tx_ready_s), 0);
        chk("midburst_rst_busy", int'(busy_s), 0);
        chk("midburst_rst_hs_data", int'(hs_data_s), 0);
        tx_req   = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk_50m);
            chk("post_rst_busy", int'(busy_s), 0);
            chk("post_rst_lp", int'({lp_p_s, lp_n_s}), 3);
        end
        mon_en = 1'b1;

        sel = 1'b1;
        @(negedge clk_50m);
        bq = '{8'h11, 8'h22, 8'h33};
        run_burst(1'b0, 1'b0);
        bq = '{8'h90};
        run_burst(1'b1, 1'b1);
        bq = '{8'h01};
        run_burst(1'b0, 1'b0);
        random_bursts(8);

        repeat (5) @(negedge clk_50m);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
